arm_sequencer: RTL and testbench
================================

# arm_sequencer

Pick-and-place motion sequencer that sits directly upstream of the arm angle/PWM stage and drives its `xita1`, `xita2` and `catch` inputs. On a start request it latches a pick pose and a place pose. It slews both joint angles one degree per step tick toward each pose and times the gripper close/open dwell. It then returns the arm to home. Slew limiting prevents servo current spikes and load swing from instantaneous angle jumps.

## Interface
- `HOME1`, default 90: joint-1 home angle in degrees.
- `HOME2`, default 90: joint-2 home angle in degrees.
- `ANGLE_MAX`, default 180: upper clamp for all target angles, in degrees.
- `STEP_CYCLES`, default 1_000_000: clk cycles per 1-degree step (20 ms at 50 MHz); must be ≥1.
- `DWELL_CYCLES`, default 25_000_000: clk cycles the gripper is held in GRIP and RELEASE; must be ≥1.
- `clk` input 1: system clock, single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: level-sampled request; accepted only in IDLE.
- `pick1`, `pick2` input 32: pick-pose joint angles in unsigned degrees.
- `place1`, `place2` input 32: place-pose joint angles in unsigned degrees.
- `xita1`, `xita2` output 32: commanded joint angles, registered, fed to the angle/PWM stage.
- `catch` output 1: gripper command, registered; 1 means close.
- `busy` output 1: high from the cycle after `start` is accepted until the sequence completes.
- `done` output 1: single-cycle pulse when the sequence returns to IDLE.

## Operation
- States: IDLE → MOVE_PICK → GRIP → MOVE_PLACE → RELEASE → MOVE_HOME → IDLE.
- IDLE accepting `start=1`:
  - Latch all four targets, each clamped to `min(value, ANGLE_MAX)`.
  - Go to MOVE_PICK.
  - `start` is ignored in every other state.
- MOVE_* states:
  - Targets are the pick pose, the place pose, or (HOME1, HOME2) respectively.
  - The step counter clears on state entry and increments every cycle.
  - When the counter equals `STEP_CYCLES-1`: each axis whose angle differs from its target moves ±1 toward it, and the counter returns to 0.
  - Both axes step on the same tick.
  - Whenever both axes equal their targets, the next cycle enters the following state. This includes the entry cycle, so a zero-distance move lasts exactly 1 cycle.
- GRIP: `catch` is set to 1 on the entry cycle. The state lasts exactly `DWELL_CYCLES` cycles, then goes to MOVE_PLACE.
- RELEASE: `catch` is set to 0 on the entry cycle. The state lasts exactly `DWELL_CYCLES` cycles, then goes to MOVE_HOME.
- MOVE_HOME completion:
  - The next cycle is IDLE, with `done=1` for that one cycle and `busy=0` from that cycle.
- Arithmetic:
  - Angles are held as unsigned 32-bit values.
  - Because targets are clamped and steps are ±1 toward the target, the angle never wraps and never exceeds ANGLE_MAX.
- Counters must be wide enough for `max(STEP_CYCLES, DWELL_CYCLES)`.

## Timing
- Reset values:
  - `xita1=HOME1`, `xita2=HOME2`
  - `catch=0`, `busy=0`, `done=0`
  - state IDLE, all counters 0
- Reset mid-sequence: on the next edge all outputs take their reset values. The angle jumps to home at once; no slew on reset.
- `start` sampled at edge t: `busy=1` and state MOVE_PICK at t+1.
- Slew timing: the first angle change appears STEP_CYCLES cycles after MOVE entry.
  - A move of N degrees (the larger axis distance) occupies N·STEP_CYCLES+1 cycles in the state.
- Total sequence length is the sum of the three move durations plus 2·DWELL_CYCLES.
- `start` held high through completion: a new sequence is accepted at the IDLE cycle where `done=1`, so `busy` returns to 1 on the following cycle.
- `start` and `rst` high together: reset wins.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: STEP_CYCLES=4, DWELL_CYCLES=8, HOME 90/90, ANGLE_MAX=180.
- Reset: assert `rst` 2 cycles → `xita1=90`, `xita2=90`, `catch=0`, `busy=0`, `done=0`. Pulse `start` with `rst` high → sequence does not start.
- Full sequence, pick (88,93), place (91,90):
  - `xita1` steps 90→89→88 and `xita2` steps 90→91→92→93, each step 4 cycles apart.
  - `catch=1` for 8 cycles, then the arm moves to (91,90) and `catch=0` for 8 cycles.
  - The arm returns to (90,90), then `done` pulses once and `busy` falls.
- Zero-distance moves, pick=place=(90,90) → each move state lasts 1 cycle. Total busy = 3+16 cycles, and `done` pulses exactly once.
- Clamp, pick (500,0) → `xita1` ramps 90 to 180 and stops. `xita2` ramps to 0 with no underflow, staying 0 afterward.
- `start` pulsed during MOVE_PLACE → ignored, with no re-latch of targets. `start` held high continuously → back-to-back sequences separated by exactly one IDLE cycle.
- Reset asserted during GRIP → next cycle `catch=0`, angles at 90/90, `busy=0`, and no `done` pulse.

Source files
------------

// File: rtl/arm_sequencer.sv
// Pick-and-place motion sequencer. It latches a pick pose and a place pose, slews both
// joint angles one degree per step tick toward each pose in turn, and times the gripper
// dwells. It then returns the arm to its home pose.
module arm_sequencer #(
  parameter int unsigned HOME1        = 90,
  parameter int unsigned HOME2        = 90,
  parameter int unsigned ANGLE_MAX    = 180,
  parameter int unsigned STEP_CYCLES  = 1_000_000,
  parameter int unsigned DWELL_CYCLES = 25_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pick1_i,
  input  logic [31:0] pick2_i,
  input  logic [31:0] place1_i,
  input  logic [31:0] place2_i,
  output logic [31:0] xita1_o,
  output logic [31:0] xita2_o,
  output logic        catch_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned CntMax = (STEP_CYCLES > DWELL_CYCLES) ? STEP_CYCLES : DWELL_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] StepLast  = CntW'(STEP_CYCLES - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [31:0] Home1    = 32'(HOME1);
  localparam logic [31:0] Home2    = 32'(HOME2);
  localparam logic [31:0] AngleMax = 32'(ANGLE_MAX);

  typedef enum logic [2:0] {
    StIdle, StMovePick, StGrip, StMovePlace, StRelease, StMoveHome
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     xita1_q, xita1_d, xita2_q, xita2_d;
  logic [31:0]     pick1_q, pick1_d, pick2_q, pick2_d;
  logic [31:0]     place1_q, place1_d, place2_q, place2_d;
  logic            catch_q, catch_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]     tgt1, tgt2;
  logic            at_tgt;

  function automatic logic [31:0] clamp(input logic [31:0] v);
    return (v > AngleMax) ? AngleMax : v;
  endfunction

  // One degree toward the target; holds once there, so no wrap is possible.
  function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt);
    if (cur < tgt) return cur + 32'd1;
    if (cur > tgt) return cur - 32'd1;
    return cur;
  endfunction

  // Select the pose the current move state is slewing toward.
  always_comb begin
    tgt1 = Home1;
    tgt2 = Home2;
    case (state_q)
      StMovePick:  begin tgt1 = pick1_q;  tgt2 = pick2_q;  end
      StMovePlace: begin tgt1 = place1_q; tgt2 = place2_q; end
      default:     ;
    endcase
    at_tgt = (xita1_q == tgt1) && (xita2_q == tgt2);
  end

  // Next-state, slew and dwell timing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    xita1_d  = xita1_q;
    xita2_d  = xita2_q;
    pick1_d  = pick1_q;
    pick2_d  = pick2_q;
    place1_d = place1_q;
    place2_d = place2_q;
    catch_d  = catch_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          pick1_d  = clamp(pick1_i);
          pick2_d  = clamp(pick2_i);
          place1_d = clamp(place1_i);
          place2_d = clamp(place2_i);
          cnt_d    = '0;
          state_d  = StMovePick;
        end
      end
      StMovePick, StMovePlace, StMoveHome: begin
        if (at_tgt) begin
          cnt_d = '0;
          case (state_q)
            StMovePick: begin
              state_d = StGrip;
              catch_d = 1'b1;
            end
            StMovePlace: begin
              state_d = StRelease;
              catch_d = 1'b0;
            end
            default: begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          endcase
        end else if (cnt_q == StepLast) begin
          xita1_d = step_toward(xita1_q, tgt1);
          xita2_d = step_toward(xita2_q, tgt2);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGrip, StRelease: begin
        if (cnt_q == DwellLast) begin
          cnt_d   = '0;
          state_d = (state_q == StGrip) ? StMovePlace : StMoveHome;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset snaps the arm home with no slew.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      xita1_q  <= Home1;
      xita2_q  <= Home2;
      pick1_q  <= '0;
      pick2_q  <= '0;
      place1_q <= '0;
      place2_q <= '0;
      catch_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      xita1_q  <= xita1_d;
      xita2_q  <= xita2_d;
      pick1_q  <= pick1_d;
      pick2_q  <= pick2_d;
      place1_q <= place1_d;
      place2_q <= place2_d;
      catch_q  <= catch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign xita1_o = xita1_q;
  assign xita2_o = xita2_q;
  assign catch_o = catch_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_arm_sequencer.sv
// Scoreboard bench for arm_sequencer: each accepted start expands into the full expected
// per-cycle trajectory; a monitor pops one entry per cycle and expects idle outputs otherwise.
module tb_arm_sequencer;

  localparam int Step  = 4;
  localparam int Dwell = 8;
  localparam int Home  = 90;
  localparam int AMax  = 180;

  logic        clk, rst, start;
  logic [31:0] pick1, pick2, place1, place2;
  logic [31:0] xita1, xita2;
  logic        catch_w, busy, done;

  typedef struct {
    logic [31:0] x1;
    logic [31:0] x2;
    logic        c;
    logic        b;
    logic        d;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;

  arm_sequencer #(
    .HOME1       (Home),
    .HOME2       (Home),
    .ANGLE_MAX   (AMax),
    .STEP_CYCLES (Step),
    .DWELL_CYCLES(Dwell)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .pick1_i (pick1),
    .pick2_i (pick2),
    .place1_i(place1),
    .place2_i(place2),
    .xita1_o (xita1),
    .xita2_o (xita2),
    .catch_o (catch_w),
    .busy_o  (busy),
    .done_o  (done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int clampi(input logic [31:0] v);
    return (v > 32'(AMax)) ? AMax : int'(v);
  endfunction

  task automatic push_one(input int a1, input int a2, input bit c, input bit b, input bit d);
    exp_t e;
    e.x1 = 32'(a1); e.x2 = 32'(a2); e.c = c; e.b = b; e.d = d;
    sb.push_back(e);
  endtask

  // Move from (cur1,cur2) to (t1,t2): one degree per axis every Step cycles, plus exit cycle.
  task automatic push_move(inout int cur1, inout int cur2, input int t1, input int t2,
                           input bit c);
    int d1, d2, n, s, m1, m2;
    d1 = t1 - cur1;
    d2 = t2 - cur2;
    n  = (d1 < 0 ? -d1 : d1);
    if ((d2 < 0 ? -d2 : d2) > n) n = (d2 < 0 ? -d2 : d2);
    for (int k = 0; k <= n * Step; k++) begin
      s  = k / Step;
      m1 = (s < (d1 < 0 ? -d1 : d1)) ? s : (d1 < 0 ? -d1 : d1);
      m2 = (s < (d2 < 0 ? -d2 : d2)) ? s : (d2 < 0 ? -d2 : d2);
      push_one(cur1 + (d1 < 0 ? -m1 : m1), cur2 + (d2 < 0 ? -m2 : m2), c, 1'b1, 1'b0);
    end
    cur1 = t1;
    cur2 = t2;
  endtask

  task automatic push_seq(input logic [31:0] p1, input logic [31:0] p2,
                          input logic [31:0] q1, input logic [31:0] q2);
    int c1, c2;
    c1 = Home;
    c2 = Home;
    push_move(c1, c2, clampi(p1), clampi(p2), 1'b0);
    for (int k = 0; k < Dwell; k++) push_one(c1, c2, 1'b1, 1'b1, 1'b0);
    push_move(c1, c2, clampi(q1), clampi(q2), 1'b1);
    for (int k = 0; k < Dwell; k++) push_one(c1, c2, 1'b0, 1'b1, 1'b0);
    push_move(c1, c2, Home, Home, 1'b0);
    push_one(Home, Home, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- monitor ----------------
  task automatic check(input string name, input exp_t e);
    total++;
    if (xita1 !== e.x1 || xita2 !== e.x2 || catch_w !== e.c || busy !== e.b || done !== e.d)
    begin
      bad++;
      $display("FAIL %s @%0t: got x1=%0d x2=%0d catch=%b busy=%b done=%b, want x1=%0d x2=%0d catch=%b busy=%b done=%b",
               name, $time, xita1, xita2, catch_w, busy, done, e.x1, e.x2, e.c, e.b, e.d);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("trace", e);
        end else begin
          e.x1 = 32'(Home); e.x2 = 32'(Home); e.c = 1'b0; e.b = 1'b0; e.d = 1'b0;
          check("idle", e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change just after the monitor's negedge sample, ahead of the next posedge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_pose(input int p1, input int p2, input int q1, input int q2);
    pick1 = 32'(p1); pick2 = 32'(p2); place1 = 32'(q1); place2 = 32'(q2);
  endtask

  // Drive start for one cycle; the model accepts it only when it believes the DUT is idle.
  task automatic pulse_start(input int p1, input int p2, input int q1, input int q2);
    set_pose(p1, p2, q1, q2);
    start = 1'b1;
    if (!rst && sb.size() == 0) push_seq(pick1, pick2, place1, place2);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (sb.size() > 0 && n < limit) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d expected entries still pending after %0d cycles", sb.size(),
               limit);
      sb.delete();
    end
  endtask

  function automatic int rnd_angle();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 400));
    return int'($urandom_range(84, 96));
  endfunction

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_pose(0, 0, 0, 0);
    tick();
    mon_en = 1'b1;
    // Reset held, start pulsed alongside: must not launch.
    tick();
    start = 1'b1;
    set_pose(100, 100, 100, 100);
    tick();
    tick();
    start = 1'b0;
    rst = 1'b0;
    repeat (2) tick();

    // Full sequence with small moves in both directions.
    pulse_start(88, 93, 91, 90);
    wait_done(500);
    repeat (2) tick();

    // Zero-distance moves.
    pulse_start(90, 90, 90, 90);
    wait_done(100);
    repeat (2) tick();

    // Clamp above ANGLE_MAX and ramp to zero without underflow.
    pulse_start(500, 0, 90, 90);
    wait_done(2000);
    repeat (2) tick();

    // Start pulsed during MOVE_PLACE with different targets: ignored, no re-latch.
    pulse_start(88, 93, 91, 90);
    repeat (22) tick();
    pulse_start(0, 180, 180, 0);
    wait_done(500);
    repeat (2) tick();

    // Start held high: back-to-back sequences with one IDLE cycle between.
    start = 1'b1;
    for (int s = 0; s < 3; s++) begin
      set_pose(rnd_angle(), rnd_angle(), rnd_angle(), rnd_angle());
      push_seq(pick1, pick2, place1, place2);
      while (sb.size() > 0) tick();
    end
    start = 1'b0;
    repeat (3) tick();

    // Reset during GRIP: everything snaps home, no done pulse.
    pulse_start(92, 88, 90, 90);
    repeat (12) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Randomized start/pose/reset traffic.
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 3) == 0);
      set_pose(rnd_angle(), rnd_angle(), rnd_angle(), rnd_angle());
      if (rst) sb.delete();
      else if (start && sb.size() == 0) push_seq(pick1, pick2, place1, place2);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    wait_done(2000);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
